hc595_driver: RTL and testbench

HC595_DRIVER -- requirements
Module: hc595_driver

---
 rtl/hc595_driver.sv | 111 +++++++++++
 tb/tb_hc595_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_driver.sv
// Serial driver for one or more chained 74HC595 shift registers.
// Shifts a WIDTH-bit word out LSB first, then pulses the latch clock low.
module hc595_driver #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DIN,
   input  logic             VALID,
   output logic             READY,
   output logic             SER,
   output logic             SCLK,
   output logic             LCLK,
   output logic             DONE
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LATCH} state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic [WIDTH:0]   w_ext;
   logic             r_ser, r_sclk, r_lclk, r_done;
   logic             w_done_nxt;
   logic             w_phase_end;

   assign w_phase_end = (r_div == DIV_W'(CLK_DIV - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;
      // ones enter from the top so the register is all ones again once idle
      w_ext       = {1'b1, r_shift};
      unique case (r_state)
         IDLE: begin
            if (VALID) begin
               w_state_nxt = SETUP;
               w_shift_nxt = DIN;
               w_cnt_nxt   = '0;
               w_div_nxt   = '0;
            end
         end
         SETUP: begin
            if (w_phase_end) begin
               w_div_nxt   = '0;
               w_state_nxt = SHIFT;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         SHIFT: begin
            if (w_phase_end) begin
               w_div_nxt   = '0;
               w_shift_nxt = w_ext[WIDTH:1];
               w_cnt_nxt   = r_cnt + 1'b1;
               w_state_nxt = (w_cnt_nxt < CNT_W'(WIDTH)) ? SETUP : LATCH;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         LATCH: begin
            if (w_phase_end) begin
               w_div_nxt   = '0;
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so they change cleanly on CLK.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_cnt   <= '0;
         r_shift <= '1;
         r_ser   <= 1'b1;
         r_sclk  <= 1'b1;
         r_lclk  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_sclk  <= (w_state_nxt != SHIFT);
         r_lclk  <= (w_state_nxt != LATCH);
         r_ser   <= ((w_state_nxt == SETUP) || (w_state_nxt == SHIFT)) ? w_shift_nxt[0] : 1'b1;
         r_done  <= w_done_nxt;
      end
   end

   assign READY = (r_state == IDLE);
   assign SER   = r_ser;
   assign SCLK  = r_sclk;
   assign LCLK  = r_lclk;
   assign DONE  = r_done;

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver: an 8-bit/div-4 instance and a 16-bit/div-1 instance,
// each feeding a behavioural 595 model (right-shifting so consumer bit i ends up as DIN[i]).
module tb_hc595_driver;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic [7:0]  din;
   logic        valid;
   logic        ready, ser, sclk, lclk, done;
   logic [15:0] din2;
   logic        valid2;
   logic        ready2, ser2, sclk2, lclk2, done2;

   logic [7:0]  m_sr = 8'h00, m_data = 8'h00;
   logic [15:0] m2_sr = 16'h0000, m2_data = 16'h0000;
   int          sclk_falls = 0, lclk_falls = 0, sclk2_falls = 0, lclk2_falls = 0;
   int          n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   hc595_driver #(.WIDTH(8), .CLK_DIV(4)) u_dut (
      .CLK(clk), .RST_N(rst_n), .DIN(din), .VALID(valid), .READY(ready),
      .SER(ser), .SCLK(sclk), .LCLK(lclk), .DONE(done)
   );

   hc595_driver #(.WIDTH(16), .CLK_DIV(1)) u_dut16 (
      .CLK(clk), .RST_N(rst2_n), .DIN(din2), .VALID(valid2), .READY(ready2),
      .SER(ser2), .SCLK(sclk2), .LCLK(lclk2), .DONE(done2)
   );

   always @(negedge sclk) begin
      m_sr       <= {ser, m_sr[7:1]};
      sclk_falls <= sclk_falls + 1;
   end
   always @(negedge lclk) begin
      m_data     <= m_sr;
      lclk_falls <= lclk_falls + 1;
   end
   always @(negedge sclk2) begin
      m2_sr       <= {ser2, m2_sr[15:1]};
      sclk2_falls <= sclk2_falls + 1;
   end
   always @(negedge lclk2) begin
      m2_data     <= m2_sr;
      lclk2_falls <= lclk2_falls + 1;
   end

   task automatic test_reset();
      rst_n = 1'b1; rst2_n = 1'b1; valid = 1'b0; valid2 = 1'b0; din = '0; din2 = '0;
      #1 rst_n = 1'b0; rst2_n = 1'b0;
      #2;
      n_checks++; if (sclk !== 1'b1) $display("FAIL rst_sclk: got %b want 1", sclk); else n_pass++;
      n_checks++; if (lclk !== 1'b1) $display("FAIL rst_lclk: got %b want 1", lclk); else n_pass++;
      n_checks++; if (ser !== 1'b1) $display("FAIL rst_ser: got %b want 1", ser); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
      n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else n_pass++;
      n_checks++; if (ready2 !== 1'b1 || sclk2 !== 1'b1) $display("FAIL rst16_idle: ready %b sclk %b want 1 1", ready2, sclk2); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_word(input logic [7:0] w);
      int n;
      n = 0;
      din = w; valid = 1'b1;
      @(negedge clk); n++;
      valid = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk); n++;
      end
      n_checks++; if (done !== 1'b1) $display("FAIL load_timeout: done %b after %0d cycles, want 1", done, n); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n, first_fall, done_n, low_cycles, latch_bad, base_s, base_l;
      n = 0; first_fall = 0; done_n = 0; low_cycles = 0; latch_bad = 0;
      base_s = sclk_falls; base_l = lclk_falls;
      din = 8'hA5; valid = 1'b1;
      while (done_n == 0 && n < 200) begin
         @(negedge clk); n++;
         if (n == 1) begin
            valid = 1'b0; din = 8'h00;
            n_checks++; if (ready !== 1'b0) $display("FAIL basic_busy: ready %b want 0", ready); else n_pass++;
         end
         if (!sclk && first_fall == 0) first_fall = n;
         if (!lclk) begin
            low_cycles++;
            if (!sclk || !ser) latch_bad++;
         end
         if (done) done_n = n;
      end
      n_checks++; if (first_fall - 1 !== 4) $display("FAIL basic_first_sclk: got %0d want 4", first_fall - 1); else n_pass++;
      n_checks++; if (done_n - 1 !== 68) $display("FAIL basic_done_latency: got %0d want 68", done_n - 1); else n_pass++;
      n_checks++; if (ready !== 1'b1) $display("FAIL basic_ready_at_done: got %b want 1", ready); else n_pass++;
      n_checks++; if (low_cycles !== 4) $display("FAIL basic_lclk_width: got %0d want 4", low_cycles); else n_pass++;
      n_checks++; if (latch_bad !== 0) $display("FAIL basic_latch_pins: %0d bad cycles want 0", latch_bad); else n_pass++;
      n_checks++; if (sclk_falls - base_s !== 8) $display("FAIL basic_sclk_falls: got %0d want 8", sclk_falls - base_s); else n_pass++;
      n_checks++; if (lclk_falls - base_l !== 1) $display("FAIL basic_lclk_falls: got %0d want 1", lclk_falls - base_l); else n_pass++;
      n_checks++; if (m_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", m_data); else n_pass++;
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else n_pass++;
      n_checks++; if (ser !== 1'b1 || sclk !== 1'b1) $display("FAIL basic_idle_pins: ser %b sclk %b want 1 1", ser, sclk); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n, d1, d2, base_s, base_l;
      n = 0; d1 = 0; d2 = 0;
      base_s = sclk_falls; base_l = lclk_falls;
      din = 8'h3C; valid = 1'b1;
      while (d2 == 0 && n < 400) begin
         @(negedge clk); n++;
         if (n == 1) din = 8'hC3;
         if (done) begin
            if (d1 == 0) begin
               d1 = n;
               n_checks++; if (ready !== 1'b1) $display("FAIL b2b_ready_at_done: got %b want 1", ready); else n_pass++;
               n_checks++; if (m_data !== 8'h3C) $display("FAIL b2b_first_data: got %h want 3c", m_data); else n_pass++;
            end else begin
               d2 = n;
            end
         end
         if (d1 != 0 && n == d1 + 1) begin
            n_checks++; if (ready !== 1'b0) $display("FAIL b2b_no_gap: ready %b want 0", ready); else n_pass++;
            valid = 1'b0;
         end
      end
      n_checks++; if (d1 - 1 !== 68) $display("FAIL b2b_done1: got %0d want 68", d1 - 1); else n_pass++;
      n_checks++; if (d2 - d1 !== 69) $display("FAIL b2b_done2_spacing: got %0d want 69", d2 - d1); else n_pass++;
      n_checks++; if (sclk_falls - base_s !== 16) $display("FAIL b2b_sclk_falls: got %0d want 16", sclk_falls - base_s); else n_pass++;
      n_checks++; if (lclk_falls - base_l !== 2) $display("FAIL b2b_lclk_falls: got %0d want 2", lclk_falls - base_l); else n_pass++;
      n_checks++; if (m_data !== 8'hC3) $display("FAIL b2b_second_data: got %h want c3", m_data); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      int n, done_n, busy_bad, base_l;
      n = 0; done_n = 0; busy_bad = 0; base_l = lclk_falls;
      din = 8'h0F; valid = 1'b1;
      while (done_n == 0 && n < 200) begin
         @(negedge clk); n++;
         if (n == 1) din = 8'hFF;
         if (done) done_n = n;
         else if (ready) busy_bad++;
         if (!lclk) valid = 1'b0;
      end
      n_checks++; if (busy_bad !== 0) $display("FAIL ignore_ready_low: %0d ready cycles want 0", busy_bad); else n_pass++;
      n_checks++; if (done_n - 1 !== 68) $display("FAIL ignore_done_latency: got %0d want 68", done_n - 1); else n_pass++;
      n_checks++; if (lclk_falls - base_l !== 1) $display("FAIL ignore_lclk_falls: got %0d want 1", lclk_falls - base_l); else n_pass++;
      n_checks++; if (m_data !== 8'h0F) $display("FAIL ignore_data: got %h want 0f", m_data); else n_pass++;
      @(negedge clk);
      n_checks++; if (ready !== 1'b1) $display("FAIL ignore_stays_idle: ready %b want 1", ready); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int n, base_s, base_l;
      load_word(8'h55);
      n_checks++; if (m_data !== 8'h55) $display("FAIL abort_preload: got %h want 55", m_data); else n_pass++;
      base_s = sclk_falls; base_l = lclk_falls;
      din = 8'hAA; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      n = 0;
      while (sclk_falls - base_s < 3 && n < 200) begin
         @(negedge clk); n++;
      end
      n_checks++; if (sclk !== 1'b0) $display("FAIL abort_mid_shift: sclk %b want 0", sclk); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (sclk !== 1'b1 || lclk !== 1'b1 || ser !== 1'b1) $display("FAIL abort_pins: sclk %b lclk %b ser %b want 1 1 1", sclk, lclk, ser); else n_pass++;
      n_checks++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL abort_ready_done: ready %b done %b want 1 0", ready, done); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++; if (lclk_falls !== base_l) $display("FAIL abort_no_latch: got %0d falls want %0d", lclk_falls, base_l); else n_pass++;
      n_checks++; if (m_data !== 8'h55) $display("FAIL abort_data_kept: got %h want 55", m_data); else n_pass++;
      rst_n = 1'b1; din = 8'h81; valid = 1'b1;
      @(negedge clk);
      n_checks++; if (ready !== 1'b0) $display("FAIL abort_first_edge_accept: ready %b want 0", ready); else n_pass++;
      valid = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk); n++;
      end
      n_checks++; if (m_data !== 8'h81) $display("FAIL abort_next_data: got %h want 81", m_data); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_wide();
      int n, first_fall, done_n, base_s, base_l;
      n = 0; first_fall = 0; done_n = 0;
      base_s = sclk2_falls; base_l = lclk2_falls;
      din2 = 16'h12F0; valid2 = 1'b1;
      while (done_n == 0 && n < 200) begin
         @(negedge clk); n++;
         if (n == 1) valid2 = 1'b0;
         if (!sclk2 && first_fall == 0) first_fall = n;
         if (done2) done_n = n;
      end
      n_checks++; if (first_fall - 1 !== 1) $display("FAIL wide_first_sclk: got %0d want 1", first_fall - 1); else n_pass++;
      n_checks++; if (done_n - 1 !== 33) $display("FAIL wide_done_latency: got %0d want 33", done_n - 1); else n_pass++;
      n_checks++; if (sclk2_falls - base_s !== 16) $display("FAIL wide_sclk_falls: got %0d want 16", sclk2_falls - base_s); else n_pass++;
      n_checks++; if (lclk2_falls - base_l !== 1) $display("FAIL wide_lclk_falls: got %0d want 1", lclk2_falls - base_l); else n_pass++;
      n_checks++; if (m2_data[7:0] !== 8'hF0) $display("FAIL wide_stage0: got %h want f0", m2_data[7:0]); else n_pass++;
      n_checks++; if (m2_data[15:8] !== 8'h12) $display("FAIL wide_stage1: got %h want 12", m2_data[15:8]); else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_busy();
      test_reset_abort();
      test_wide();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
